// File: rtl/bhr_update_ctrl.sv
// bhr_update_ctrl: global-history driver for a k-bit PHT predictor.
// Owns the speculative and architectural GHRs, supplies the PHT lookup index,
// tracks in-flight predicted branches in an in-order FIFO, and on in-order
// resolution issues the PHT counter update and repairs history on a mispredict.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   pred_valid/taken/ready    fetch-side predicted-branch handshake
//   pht_index                 PHT lookup index (speculative history, comb)
//   res_valid/taken           resolution of the oldest in-flight branch
//   upd_valid/index/taken     registered PHT update strobe and payload
//   mispredict                registered redirect pulse
//   res_err                   registered pulse: resolve with nothing in flight
//   count                     in-flight entries
//   arch_ghr                  committed history
module bhr_update_ctrl #(
    parameter int unsigned K     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    output logic [K-1:0]               pht_index,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       upd_valid,
    output logic [K-1:0]               upd_index,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic                       res_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic [K-1:0]               arch_ghr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [K-1:0] idx;
        logic         taken;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [K-1:0]    spec_ghr;

    logic            push;
    logic            pop;
    logic            mis;
    entry_t          head;

    // Full/empty come only from the registered count; no pop bypass.
    assign pred_ready = (count != CW'(DEPTH));
    assign pht_index  = spec_ghr;

    assign push = pred_valid && pred_ready;
    assign pop  = res_valid && (count != '0);
    assign head = fifo_mem[rd_ptr];
    assign mis  = pop && (head.taken != res_taken);

    // Entry storage; stale contents are harmless because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{idx: spec_ghr, taken: pred_taken};
        end
    end

    // Pointers, count and both histories. A mispredict flush overrides any
    // same-cycle push: the accepted entry is dropped and fetch re-sends it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            spec_ghr <= '0;
            arch_ghr <= '0;
        end else begin
            if (pop) begin
                arch_ghr <= {arch_ghr[K-2:0], res_taken};
            end
            if (mis) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                spec_ghr <= {arch_ghr[K-2:0], res_taken};
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    spec_ghr <= {spec_ghr[K-2:0], pred_taken};
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // One-cycle registered event outputs; payload is zeroed when not updating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_valid  <= 1'b0;
            upd_index  <= '0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            upd_valid  <= pop;
            upd_index  <= pop ? head.idx : '0;
            upd_taken  <= pop && res_taken;
            mispredict <= mis;
            res_err    <= res_valid && (count == '0);
        end
    end

endmodule

// File: tb/tb_bhr_update_ctrl.sv
module tb_bhr_update_ctrl;

    localparam int unsigned K     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NV    = 23;

    logic         clk;
    logic         reset_n;
    logic         pred_valid;
    logic         pred_taken;
    logic         pred_ready;
    logic [3:0]   pht_index;
    logic         res_valid;
    logic         res_taken;
    logic         upd_valid;
    logic [3:0]   upd_index;
    logic         upd_taken;
    logic         mispredict;
    logic         res_err;
    logic [2:0]   count;
    logic [3:0]   arch_ghr;

    typedef struct packed {
        logic       rdy;
        logic [3:0] pht;
        logic       uv;
        logic [3:0] ui;
        logic       ut;
        logic       mp;
        logic       re;
        logic [2:0] cnt;
        logic [3:0] arch;
    } obs_t;

    typedef struct packed {
        logic pv;
        logic pt;
        logic rv;
        logic rt;
        obs_t exp;
    } vec_t;

    vec_t vecs [NV];
    obs_t got;
    int   n_tests;
    int   n_fail;

    bhr_update_ctrl #(.K(K), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ready (pred_ready),
        .pht_index  (pht_index),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .res_err    (res_err),
        .count      (count),
        .arch_ghr   (arch_ghr)
    );

    assign got = '{rdy: pred_ready, pht: pht_index, uv: upd_valid, ui: upd_index,
                   ut: upd_taken, mp: mispredict, re: res_err, cnt: count,
                   arch: arch_ghr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic pv, input logic pt, input logic rv,
                                input logic rt, input logic rdy, input logic [3:0] pht,
                                input logic uv, input logic [3:0] ui, input logic ut,
                                input logic mp, input logic re, input logic [2:0] cnt,
                                input logic [3:0] arch);
        vec_t v;
        v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt;
        v.exp = '{rdy: rdy, pht: pht, uv: uv, ui: ui, ut: ut, mp: mp, re: re,
                  cnt: cnt, arch: arch};
        return v;
    endfunction

    task automatic check(input string name, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b pht=%h uv=%b ui=%h ut=%b mp=%b re=%b cnt=%0d arch=%h, expected rdy=%b pht=%h uv=%b ui=%h ut=%b mp=%b re=%b cnt=%0d arch=%h",
                     name, got.rdy, got.pht, got.uv, got.ui, got.ut, got.mp, got.re,
                     got.cnt, got.arch, exp.rdy, exp.pht, exp.uv, exp.ui, exp.ut,
                     exp.mp, exp.re, exp.cnt, exp.arch);
        end
    endtask

    task automatic drive(input logic pv, input logic pt, input logic rv, input logic rt);
        @(negedge clk);
        pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
        @(posedge clk);
        #1;
    endtask

    localparam obs_t IDLE0 = '{rdy: 1'b1, pht: 4'h0, uv: 1'b0, ui: 4'h0, ut: 1'b0,
                               mp: 1'b0, re: 1'b0, cnt: 3'd0, arch: 4'h0};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        // cols: pv pt rv rt | rdy pht uv ui ut mp re cnt arch
        // correct-prediction stream
        vecs[0]  = mk(1,1,0,0, 1,4'h1, 0,4'h0,0, 0,0, 3'd1, 4'h0);
        vecs[1]  = mk(1,1,0,0, 1,4'h3, 0,4'h0,0, 0,0, 3'd2, 4'h0);
        vecs[2]  = mk(1,0,0,0, 1,4'h6, 0,4'h0,0, 0,0, 3'd3, 4'h0);
        vecs[3]  = mk(0,0,1,1, 1,4'h6, 1,4'h0,1, 0,0, 3'd2, 4'h1);
        vecs[4]  = mk(0,0,1,1, 1,4'h6, 1,4'h1,1, 0,0, 3'd1, 4'h3);
        vecs[5]  = mk(0,0,1,0, 1,4'h6, 1,4'h3,0, 0,0, 3'd0, 4'h6);
        // mispredict flush
        vecs[6]  = mk(1,1,0,0, 1,4'hD, 0,4'h0,0, 0,0, 3'd1, 4'h6);
        vecs[7]  = mk(1,1,0,0, 1,4'hB, 0,4'h0,0, 0,0, 3'd2, 4'h6);
        vecs[8]  = mk(1,1,0,0, 1,4'h7, 0,4'h0,0, 0,0, 3'd3, 4'h6);
        vecs[9]  = mk(0,0,1,0, 1,4'hC, 1,4'h6,0, 1,0, 3'd0, 4'hC);
        vecs[10] = mk(0,0,0,0, 1,4'hC, 0,4'h0,0, 0,0, 3'd0, 4'hC);
        // resolve while empty
        vecs[11] = mk(0,0,1,1, 1,4'hC, 0,4'h0,0, 0,1, 3'd0, 4'hC);
        vecs[12] = mk(0,0,0,0, 1,4'hC, 0,4'h0,0, 0,0, 3'd0, 4'hC);
        // fill to DEPTH, refused push, push refused during pop while full
        vecs[13] = mk(1,0,0,0, 1,4'h8, 0,4'h0,0, 0,0, 3'd1, 4'hC);
        vecs[14] = mk(1,1,0,0, 1,4'h1, 0,4'h0,0, 0,0, 3'd2, 4'hC);
        vecs[15] = mk(1,0,0,0, 1,4'h2, 0,4'h0,0, 0,0, 3'd3, 4'hC);
        vecs[16] = mk(1,1,0,0, 0,4'h5, 0,4'h0,0, 0,0, 3'd4, 4'hC);
        vecs[17] = mk(1,1,0,0, 0,4'h5, 0,4'h0,0, 0,0, 3'd4, 4'hC);
        vecs[18] = mk(1,1,1,0, 1,4'h5, 1,4'hC,0, 0,0, 3'd3, 4'h8);
        // push + correct resolve together (pointer wrap on the push)
        vecs[19] = mk(1,0,1,1, 1,4'hA, 1,4'h8,1, 0,0, 3'd3, 4'h1);
        // push collides with a mispredicting resolve
        vecs[20] = mk(1,1,1,1, 1,4'h3, 1,4'h1,1, 1,0, 3'd0, 4'h3);
        vecs[21] = mk(0,0,0,0, 1,4'h3, 0,4'h0,0, 0,0, 3'd0, 4'h3);
        // dropped push must not be in the FIFO
        vecs[22] = mk(0,0,1,1, 1,4'h3, 0,4'h0,0, 0,1, 3'd0, 4'h3);

        // reset with traffic present on the inputs
        reset_n = 1'b0;
        pred_valid = 1'b1; pred_taken = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", IDLE0);
        @(negedge clk);
        pred_valid = 1'b0; pred_taken = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", IDLE0);

        for (int i = 0; i < int'(NV); i++) begin
            drive(vecs[i].pv, vecs[i].pt, vecs[i].rv, vecs[i].rt);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // reset asserted mid-operation with a resolve pending: no update pulse
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_reset", '{rdy: 1'b1, pht: 4'hE, uv: 1'b0, ui: 4'h0, ut: 1'b0,
                             mp: 1'b0, re: 1'b0, cnt: 3'd2, arch: 4'h3});
        @(negedge clk);
        pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", IDLE0);
        @(posedge clk);
        #1;
        @(negedge clk);
        res_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset", IDLE0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("post_reset_empty", '{rdy: 1'b1, pht: 4'h0, uv: 1'b0, ui: 4'h0, ut: 1'b0,
                                    mp: 1'b0, re: 1'b1, cnt: 3'd0, arch: 4'h0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
